// File: rtl/idct_2d_8x8_seq_pkg.sv
// Shared definitions for the 8x8 inverse DCT: Q16 coefficient table, FSM states,
// and the round/saturate step applied after each 1-D pass.
package idct_2d_8x8_seq_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FRAC_BITS_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Forward DCT table C[k][n] at index k*8+n; the inverse reads it transposed.
    localparam int COEF [64] = '{
         23170,  23170,  23170,  23170,  23170,  23170,  23170,  23170,
         32138,  27246,  18205,   6393,  -6393, -18205, -27246, -32138,
         30274,  12540, -12540, -30274, -30274, -12540,  12540,  30274,
         27246,  -6393, -32138, -18205,  18205,  32138,   6393, -27246,
         23170, -23170, -23170,  23170,  23170, -23170, -23170,  23170,
         18205, -32138,   6393,  27246, -27246,  -6393,  32138, -18205,
         12540, -30274,  30274, -12540, -12540,  30274, -30274,  12540,
          6393, -18205,  27246, -32138,  32138, -27246,  18205,  -6393
    };

    function automatic logic signed [63:0] round_sat(input logic signed [127:0] acc,
                                                     input int frac_bits,
                                                     input int data_width);
        logic signed [127:0] r;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        r  = (acc + (128'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi = (128'sd1 <<< (data_width - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (data_width - 1));
        if (r > hi)
            return hi[63:0];
        else if (r < lo)
            return lo[63:0];
        else
            return r[63:0];
    endfunction

endpackage

// File: rtl/idct_2d_8x8_seq_1d.sv
// Combinational 8-point inverse DCT: y[n] = sum_k C[k][n]*x[k], full-precision
// products, 3 guard bits, then round and saturate to DATA_WIDTH.
module idct_1d_8pt
    import idct_2d_8x8_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] x [8],
    output logic signed [DATA_WIDTH-1:0] y [8]
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [2*DATA_WIDTH+2:0] acc;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int n = 0; n < 8; n++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) begin
                prod = x[k] * DATA_WIDTH'(COEF[k*8+n]);
                acc  = acc + (2*DATA_WIDTH+3)'(prod);
            end
            y[n] = DATA_WIDTH'(round_sat(128'(acc), FRAC_BITS, DATA_WIDTH));
        end
    end

endmodule

// File: rtl/idct_2d_8x8_seq.sv
// Sequential 8x8 inverse DCT: row pass then column pass on one shared 1-D engine.
// Optional IDCT_LEVEL_SHIFT_EN adds +128 and clamps output to the pixel range.
module idct_2d_8x8_seq
    import idct_2d_8x8_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH*64-1:0] in_block,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH*64-1:0] out_block,
    output logic                     busy
);

    state_t                      state;
    logic [3:0]                  cnt;
    logic signed [DATA_WIDTH-1:0] work [64];
    logic signed [DATA_WIDTH-1:0] tbuf [64];
    logic signed [DATA_WIDTH-1:0] eng_x [8];
    logic signed [DATA_WIDTH-1:0] eng_y [8];
    logic signed [DATA_WIDTH-1:0] col_val [8];
    logic signed [DATA_WIDTH-1:0] col_res [8];
    logic                        col_wr;
    logic [2:0]                  col_idx;

    always_comb begin
        for (int i = 0; i < 8; i++)
            eng_x[i] = (state == ST_COL) ? tbuf[int'(cnt[2:0])*8+i] : work[int'(cnt[2:0])*8+i];
    end

    idct_1d_8pt #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_engine (
        .x(eng_x),
        .y(eng_y)
    );

`ifdef IDCT_LEVEL_SHIFT_EN
    logic signed [DATA_WIDTH:0] shifted;

    always_comb begin
        shifted = '0;
        for (int n = 0; n < 8; n++) begin
            shifted = (DATA_WIDTH+1)'(eng_y[n]) + (DATA_WIDTH+1)'(128 <<< FRAC_BITS);
            if (shifted < 0)
                col_val[n] = '0;
            else if (shifted > (DATA_WIDTH+1)'(255 <<< FRAC_BITS))
                col_val[n] = DATA_WIDTH'(255 <<< FRAC_BITS);
            else
                col_val[n] = shifted[DATA_WIDTH-1:0];
        end
    end
`else
    assign col_val = eng_y;
`endif

    // Column results are registered before landing in out_block, so COL has one drain cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_block <= '0;
            col_wr    <= 1'b0;
            col_idx   <= '0;
            for (int i = 0; i < 64; i++) begin
                work[i] <= '0;
                tbuf[i] <= '0;
            end
            for (int n = 0; n < 8; n++)
                col_res[n] <= '0;
        end else begin
            col_wr <= 1'b0;
            if (col_wr) begin
                for (int n = 0; n < 8; n++)
                    out_block[(n*8+int'(col_idx))*DATA_WIDTH +: DATA_WIDTH] <= col_res[n];
            end
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 64; i++)
                            work[i] <= in_block[i*DATA_WIDTH +: DATA_WIDTH];
                        state    <= ST_ROW;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_ROW: begin
                    for (int n = 0; n < 8; n++)
                        tbuf[n*8+int'(cnt[2:0])] <= eng_y[n];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        state <= ST_COL;
                        cnt   <= '0;
                    end
                end
                ST_COL: begin
                    if (cnt == 4'd8) begin
                        state     <= ST_OUT;
                        out_valid <= 1'b1;
                    end else begin
                        col_res <= col_val;
                        col_idx <= cnt[2:0];
                        col_wr  <= 1'b1;
                        cnt     <= cnt + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
